// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad one column at a time, debounces a single
//   pressed key, reports it once, and waits for a debounced release before
//   scanning again.
//
// Parameters
//   SCAN_DIV  clock cycles each column is driven (>= 2)
//   DEB_LEN   consecutive matching dwell-end samples to accept press/release (>= 1)
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   kr[3:0]    row sense, active-low
//   kc[3:0]    column drive, active-low one-hot
//   key_valid  one-cycle pulse for a newly accepted key
//   key_code   4*row + column of the last accepted key
//   key_held   high until the accepted key has been released
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEB_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] kr,
  output logic [3:0] kc,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_LEN + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_LEN);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_div;
  logic          w_tick;
  logic [1:0]    r_col, w_col_nxt;
  logic [3:0]    r_kr_lat, w_kr_lat_nxt;
  logic [CW-1:0] r_match, w_match_nxt;
  logic [CW-1:0] r_rel, w_rel_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_held, w_held_nxt;
  logic [3:0]    r_code, w_code_nxt;
  logic [CW-1:0] w_match_inc;
  logic [CW-1:0] w_rel_inc;

  // Exactly one row pulled low; anything else (idle or ghosting) is no press.
  function automatic logic is_onehot_low(input logic [3:0] k);
    return (k == 4'b1110) || (k == 4'b1101) || (k == 4'b1011) || (k == 4'b0111);
  endfunction

  function automatic logic [1:0] row_of(input logic [3:0] k);
    case (k)
      4'b1101: row_of = 2'd1;
      4'b1011: row_of = 2'd2;
      4'b0111: row_of = 2'd3;
      default: row_of = 2'd0;
    endcase
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= DEB_MAX) ? DEB_MAX : c + CW'(1);
  endfunction

  assign w_tick      = (r_div == DIV_MAX);
  assign w_match_inc = sat_inc(r_match);
  assign w_rel_inc   = sat_inc(r_rel);

  always_comb begin
    w_state_nxt  = r_state;
    w_col_nxt    = r_col;
    w_kr_lat_nxt = r_kr_lat;
    w_match_nxt  = r_match;
    w_rel_nxt    = r_rel;
    w_valid_nxt  = 1'b0;
    w_held_nxt   = r_held;
    w_code_nxt   = r_code;
    case (r_state)
      S_SCAN: begin
        if (w_tick) begin
          if (is_onehot_low(kr)) begin
            w_kr_lat_nxt = kr;
            if (DEB_LEN == 1) begin
              w_state_nxt = S_HELD;
              w_valid_nxt = 1'b1;
              w_held_nxt  = 1'b1;
              w_code_nxt  = {row_of(kr), r_col};
              w_match_nxt = '0;
              w_rel_nxt   = '0;
            end else begin
              w_state_nxt = S_DEBOUNCE;
              w_match_nxt = CW'(1);
            end
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end
      end
      S_DEBOUNCE: begin
        if (w_tick) begin
          if (kr == r_kr_lat) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == DEB_MAX) begin
              w_state_nxt = S_HELD;
              w_valid_nxt = 1'b1;
              w_held_nxt  = 1'b1;
              w_code_nxt  = {row_of(r_kr_lat), r_col};
              w_match_nxt = '0;
              w_rel_nxt   = '0;
            end
          end else begin
            w_state_nxt = S_SCAN;
            w_col_nxt   = r_col + 2'd1;
            w_match_nxt = '0;
          end
        end
      end
      S_HELD: begin
        // Column stays on the held key, so other columns' keys are invisible.
        if (w_tick) begin
          if (kr == 4'b1111) begin
            w_rel_nxt = w_rel_inc;
            if (w_rel_inc == DEB_MAX) begin
              w_state_nxt = S_SCAN;
              w_held_nxt  = 1'b0;
              w_col_nxt   = r_col + 2'd1;
              w_rel_nxt   = '0;
            end
          end else begin
            w_rel_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_SCAN;
      r_div   <= '0;
      r_col   <= 2'd0;
      r_match <= '0;
      r_rel   <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
      r_code  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_tick ? '0 : r_div + DW'(1);
      r_col   <= w_col_nxt;
      r_match <= w_match_nxt;
      r_rel   <= w_rel_nxt;
      r_valid <= w_valid_nxt;
      r_held  <= w_held_nxt;
      r_code  <= w_code_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_kr_lat <= w_kr_lat_nxt;
  end

  assign kc        = ~(4'b0001 << r_col);
  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign key_held  = r_held;

endmodule
